// File: rtl/csi2tx_pulse_throttle.sv
// csi2tx_pulse_throttle
//
// Paces event requests ahead of the CSI-2 TX pulse synchronizer. Requests
// can arrive in bursts. They are held in a saturating pending count and sent
// out again as single-cycle pulses, with at least GAP_CYC idle cycles after
// each pulse. This spacing lets the toggle synchronizer downstream see every
// event as a separate one.
//
// Ports
//   clk_in     in   1      source-domain clock (only clock)
//   rsta_n     in   1      asynchronous active-low reset
//   event_req  in   1      one event per cycle sampled high
//   clr        in   1      synchronous clear of the pending count and overflow
//   pulse_o    out  1      paced single-cycle pulse (registered)
//   pend_cnt   out  CNT_W  events queued but not yet issued (registered)
//   overflow   out  1      sticky: an event was dropped on a full queue
//   busy       out  1      state != IDLE or pend_cnt != 0 (decoded)
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing in flight; leaves as soon as an event is pending
// PULSE | pulse_o high for this single cycle
// GAP   | forced idle cycles; gap counter counts down to 0
module csi2tx_pulse_throttle #(
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 6
) (
    input  logic             clk_in,
    input  logic             rsta_n,
    input  logic             event_req,
    input  logic             clr,
    output logic             pulse_o,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       gap_q, gap_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             pulse_q, pulse_d;
    logic             issue;

    always_ff @(posedge clk_in or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q <= S_IDLE;
            gap_q   <= 8'd0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            pulse_q <= pulse_d;
        end
    end

    // An event is issued on the edge that enters PULSE. The pulse itself
    // comes from a register, so it is high only while the FSM is in PULSE.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    issue   = 1'b1;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_q == 8'd0) begin
                    if (pend_q != '0) begin
                        issue   = 1'b1;
                        state_d = S_PULSE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pulse_d = (state_d == S_PULSE);
    end

    // Pending count. clr only clears the queue; it does not stop a pulse or
    // gap that has already started, so the spacing still holds. When an
    // event arrives on an issue cycle, one event goes in and one goes out,
    // so the count stays the same (this also applies when the queue is full).
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (clr) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (event_req && !issue) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!event_req && issue) begin
            pend_d = pend_q - 1'b1;
        end
    end

    assign pulse_o  = pulse_q;
    assign pend_cnt = pend_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != S_IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_csi2tx_pulse_throttle.sv
module tb_csi2tx_pulse_throttle;

    logic       clk_in = 1'b0;
    logic       rsta_n = 1'b0;
    logic       req_a = 1'b0, clr_a = 1'b0;
    logic       req_b = 1'b0, clr_b = 1'b0;
    logic       pulse_a, ovf_a, busy_a;
    logic [3:0] pend_a;
    logic       pulse_b, ovf_b, busy_b;
    logic [1:0] pend_b;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    csi2tx_pulse_throttle #(.CNT_W(4), .GAP_CYC(6)) dut_a (
        .clk_in(clk_in), .rsta_n(rsta_n), .event_req(req_a), .clr(clr_a),
        .pulse_o(pulse_a), .pend_cnt(pend_a), .overflow(ovf_a), .busy(busy_a)
    );

    csi2tx_pulse_throttle #(.CNT_W(2), .GAP_CYC(6)) dut_b (
        .clk_in(clk_in), .rsta_n(rsta_n), .event_req(req_b), .clr(clr_b),
        .pulse_o(pulse_b), .pend_cnt(pend_b), .overflow(ovf_b), .busy(busy_b)
    );

    // One vector = the inputs applied during a cycle and the outputs expected
    // just after the next edge.
    typedef struct {
        bit       sel;   // 0 = dut_a (CNT_W=4), 1 = dut_b (CNT_W=2)
        bit       req;
        bit       clr;
        bit       pulse;
        bit [3:0] pend;
        bit       ovf;
        bit       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic void add(bit sel, bit req, bit clr, bit pulse, int pend, bit ovf, bit busy);
        vec_t v;
        v.sel = sel; v.req = req; v.clr = clr; v.pulse = pulse;
        v.pend = 4'(pend); v.ovf = ovf; v.busy = busy;
        tbl.push_back(v);
    endfunction

    task automatic run_vecs(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (tbl[i].sel) begin req_b = tbl[i].req; clr_b = tbl[i].clr; end
            else            begin req_a = tbl[i].req; clr_a = tbl[i].clr; end
            step();
            if (tbl[i].sel) begin
                chk($sformatf("%s[%0d].pulse", tag, i), int'(pulse_b), int'(tbl[i].pulse));
                chk($sformatf("%s[%0d].pend",  tag, i), int'(pend_b),  int'(tbl[i].pend));
                chk($sformatf("%s[%0d].ovf",   tag, i), int'(ovf_b),   int'(tbl[i].ovf));
                chk($sformatf("%s[%0d].busy",  tag, i), int'(busy_b),  int'(tbl[i].busy));
            end else begin
                chk($sformatf("%s[%0d].pulse", tag, i), int'(pulse_a), int'(tbl[i].pulse));
                chk($sformatf("%s[%0d].pend",  tag, i), int'(pend_a),  int'(tbl[i].pend));
                chk($sformatf("%s[%0d].ovf",   tag, i), int'(ovf_a),   int'(tbl[i].ovf));
                chk($sformatf("%s[%0d].busy",  tag, i), int'(busy_a),  int'(tbl[i].busy));
            end
        end
        req_a = 1'b0; clr_a = 1'b0; req_b = 1'b0; clr_b = 1'b0;
    endtask

    initial begin
        int n_pulse;
        int max_pend;
        int ptime[$];

        // single event on dut_a: pend 0,1,0; pulse in cycle 2; gap cycles 3..8
        add(0,1,0, 0,1,0,1);
        add(0,0,0, 1,0,0,1);
        for (int k = 0; k < 6; k++) add(0,0,0, 0,0,0,1);
        add(0,0,0, 0,0,0,0);                                // idx 0..8
        // clr during GAP, full queue, overflow already set, req with clr
        add(1,1,0, 0,1,1,1);
        add(1,1,0, 1,1,1,1);
        add(1,1,0, 0,2,1,1);
        add(1,1,0, 0,3,1,1);
        add(1,1,0, 0,3,1,1);                                // dropped, still full
        add(1,1,0, 0,3,1,1);
        add(1,1,1, 0,0,0,1);                                // clr wins over drop
        add(1,0,0, 0,0,0,1);
        add(1,0,0, 0,0,0,0);
        add(1,0,0, 0,0,0,0);                                // idx 9..18
        // full queue with req on the issue cycle
        add(1,1,0, 0,1,0,1);
        add(1,1,0, 1,1,0,1);
        add(1,1,0, 0,2,0,1);
        add(1,1,0, 0,3,0,1);
        for (int k = 0; k < 4; k++) add(1,0,0, 0,3,0,1);
        add(1,1,0, 1,3,0,1);
        add(1,0,0, 0,3,0,1);                                // idx 19..28
        // after a mid-operation reset: new event pulses 2 cycles later
        add(0,1,0, 0,1,0,1);
        add(0,0,0, 1,0,0,1);
        add(0,0,0, 0,0,0,1);                                // idx 29..31

        // reset values
        #12;
        chk("rst.pulse_a", int'(pulse_a), 0);
        chk("rst.pend_a",  int'(pend_a),  0);
        chk("rst.ovf_a",   int'(ovf_a),   0);
        chk("rst.busy_a",  int'(busy_a),  0);
        chk("rst.pend_b",  int'(pend_b),  0);
        @(negedge clk_in);
        rsta_n = 1'b1;
        step();

        run_vecs("single", 0, 8);

        // burst of 5 on dut_a: pulses at cycles 2,9,16,23,30
        n_pulse = 0; max_pend = 0;
        for (int c = 0; c < 40; c++) begin
            req_a = (c < 5);
            step();
            if (pulse_a) begin n_pulse++; ptime.push_back(c + 1); end
            if (int'(pend_a) > max_pend) max_pend = int'(pend_a);
            if (ovf_a) chk("burst.ovf", int'(ovf_a), 0);
        end
        req_a = 1'b0;
        chk("burst.count", n_pulse, 5);
        for (int i = 0; i < ptime.size() && i < 5; i++)
            chk($sformatf("burst.time%0d", i), ptime[i], 2 + 7 * i);
        chk("burst.maxpend", max_pend, 4);
        chk("burst.busy_end", int'(busy_a), 0);

        // saturation on dut_b (CNT_W=2): 6 requests, 4 accepted
        n_pulse = 0; max_pend = 0;
        for (int c = 0; c < 40; c++) begin
            req_b = (c < 6);
            step();
            if (pulse_b) n_pulse++;
            if (int'(pend_b) > max_pend) max_pend = int'(pend_b);
        end
        req_b = 1'b0;
        chk("sat.count",   n_pulse, 4);
        chk("sat.maxpend", max_pend, 3);
        chk("sat.ovf",     int'(ovf_b), 1);
        chk("sat.pend",    int'(pend_b), 0);

        run_vecs("clrgap", 9, 18);
        run_vecs("fullissue", 19, 28);
        for (int c = 0; c < 12; c++) step();

        // reset mid-GAP with pend_cnt=2 on dut_a
        for (int c = 0; c < 3; c++) begin
            req_a = 1'b1;
            step();
        end
        req_a = 1'b0;
        chk("prerst.pend", int'(pend_a), 2);
        chk("prerst.busy", int'(busy_a), 1);
        #3;
        rsta_n = 1'b0;
        #1;
        chk("asyrst.pulse", int'(pulse_a), 0);
        chk("asyrst.pend",  int'(pend_a),  0);
        chk("asyrst.ovf",   int'(ovf_a),   0);
        chk("asyrst.busy",  int'(busy_a),  0);
        chk("asyrst.pend_b", int'(pend_b), 0);
        step();
        @(negedge clk_in);
        rsta_n = 1'b1;
        step();
        chk("postrst.busy", int'(busy_a), 0);
        run_vecs("postrst", 29, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
